// File: rtl/mux.sv
// Registered N-to-1 multiplexer; out-of-range selects load zero.
// Define MUX_SEL_ERR_EN to add the registered o_sel_err flag.
module mux #(
  parameter int NUM_INPUTS = 6,
  parameter int DATA_WIDTH = 8,
  localparam int SEL_W =
    (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic [NUM_INPUTS*DATA_WIDTH-1:0] i_data_bus,
  input  logic [SEL_W-1:0]                 i_select,
`ifdef MUX_SEL_ERR_EN
  output logic                             o_sel_err,
`endif
  output logic [DATA_WIDTH-1:0]            o_output
);

  logic [DATA_WIDTH-1:0] sel_data;
  logic                  in_range;

  // Extra bit so NUM_INPUTS = 2**SEL_W still fits the compare.
  assign in_range =
    ({1'b0, i_select} < (SEL_W+1)'(NUM_INPUTS));

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (i_select == SEL_W'(k))
        sel_data = i_data_bus[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_output <= '0;
    else
      o_output <= sel_data;
  end

`ifdef MUX_SEL_ERR_EN
  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_sel_err <= 1'b0;
    else
      o_sel_err <= ~in_range;
  end
`endif

endmodule

// File: tb/tb_mux.sv
// Scoreboard bench for mux: a 6x8 and a 1x4 instance.
// Expected values come from an array model of the inputs.
module tb_mux;

  localparam int N0 = 6;
  localparam int W0 = 8;
  localparam int N1 = 1;
  localparam int W1 = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [N0*W0-1:0] bus0;
  logic [2:0]    sel0;
  logic [7:0]    out0;
  logic [N1*W1-1:0] bus1;
  logic [0:0]    sel1;
  logic [3:0]    out1;
`ifdef MUX_SEL_ERR_EN
  logic          err0;
  logic          err1;
`endif

  always #5 clk = ~clk;

  mux #(.NUM_INPUTS(N0), .DATA_WIDTH(W0)) dut0 (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_data_bus (bus0),
    .i_select   (sel0),
`ifdef MUX_SEL_ERR_EN
    .o_sel_err  (err0),
`endif
    .o_output   (out0)
  );

  mux #(.NUM_INPUTS(N1), .DATA_WIDTH(W1)) dut1 (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_data_bus (bus1),
    .i_select   (sel1),
`ifdef MUX_SEL_ERR_EN
    .o_sel_err  (err1),
`endif
    .o_output   (out1)
  );

  typedef struct {
    logic [7:0] o0;
    logic       e0;
    logic [3:0] o1;
    logic       e1;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   passed = 0;

  logic [7:0] mem0 [N0];
  logic [3:0] mem1;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, act, exp);
  endtask

  // Drive one cycle of stimulus and record the model's answer.
  task automatic step(input logic r,
                      input int s0,
                      input int s1);
    exp_t e;
    @(negedge clk);
    rst  = r;
    sel0 = 3'(s0);
    sel1 = 1'(s1);
    for (int k = 0; k < N0; k++)
      bus0[k*W0 +: W0] = mem0[k];
    bus1 = mem1;
    if (r) begin
      e.o0 = 8'h00;
      e.e0 = 1'b0;
      e.o1 = 4'h0;
      e.e1 = 1'b0;
    end else begin
      e.o0 = (s0 < N0) ? mem0[s0] : 8'h00;
      e.e0 = (s0 >= N0);
      e.o1 = (s1 < N1) ? mem1 : 4'h0;
      e.e1 = (s1 >= N1);
    end
    q.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("out0", 32'(out0), 32'(e.o0));
      chk("out1", 32'(out1), 32'(e.o1));
`ifdef MUX_SEL_ERR_EN
      chk("err0", 32'(err0), 32'(e.e0));
      chk("err1", 32'(err1), 32'(e.e1));
`endif
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    sel0 = '0;
    sel1 = '0;
    bus0 = '0;
    bus1 = '0;
    mem0[0] = 8'hFF; mem0[1] = 8'hEE;
    mem0[2] = 8'hDD; mem0[3] = 8'hCC;
    mem0[4] = 8'hBB; mem0[5] = 8'hAA;
    mem1 = 4'h9;

    step(1, 4, 1);
    step(0, 0, 0);
    step(0, 1, 1);
    step(0, 2, 0);
    step(0, 5, 1);
    step(0, 7, 0);
    step(0, 6, 1);
    step(0, 3, 0);
    step(0, 0, 0);
    mem0[0] = 8'h5A;
    step(0, 0, 1);
    mem0[0] = 8'hFF;
    step(0, 2, 0);
    step(1, 2, 0);
    step(0, 2, 0);
    step(0, 2, 1);

    for (int i = 0; i < 300; i++) begin
      for (int k = 0; k < N0; k++)
        mem0[k] = 8'($urandom);
      mem1 = 4'($urandom);
      step(($urandom_range(0, 15) == 0),
           int'($urandom_range(0, 7)),
           int'($urandom_range(0, 1)));
    end

    n = 0;
    while (q.size() > 0 && n < 20) begin
      @(posedge clk);
      n++;
    end
    #2;
    if (q.size() > 0) begin
      total++;
      $display("FAIL drain: %0d left expected 0",
               q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
